// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit -- multiply/divide unit for the EX stage of the five-stage pipeline
//
// Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and MTHI/MTLO
// in a single cycle. The architectural HI/LO registers are exposed
// combinationally for EX/MEM forwarding. While a multi-cycle op is in flight,
// busy is high so that the hazard controller can stall later mul/div-class
// instructions.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 7..10). These ops accumulate into {hi,lo} with MUL_CYCLES latency.
// When the macro is undefined, those op codes are treated as no-ops.
//
// Parameters:
//   MUL_CYCLES  busy cycles for multiply-class ops (1..15)
//   DIV_CYCLES  busy cycles for divide-class ops   (1..15)
//
// Ports:
//   clk     in   pipeline clock, rising edge
//   reset   in   asynchronous, active-high reset
//   start   in   the EX-stage instruction is an MDU op this cycle
//   req     in   flush request; cancels a start in the same cycle
//   mdu_op  in   [3:0] op code (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU)
//   A       in   [31:0] forwarded rs value
//   B       in   [31:0] forwarded rt value
//   busy    out  a multi-cycle op is in flight
//   hi      out  [31:0] architectural HI register
//   lo      out  [31:0] architectural LO register
// ---------------------------------------------------------------------------
module mdu_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] pending;        // result waiting for commit
  logic        pending_write;  // clear for divide-by-zero: hi/lo keep prior values

  // -------------------------------------------------------------------------
  // Arithmetic. This is evaluated from the live operands and is captured only
  // at the accept edge.
  // -------------------------------------------------------------------------
  logic        accept;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        b_zero;
  logic [31:0] divisor_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign accept = start && !req && (state == ST_IDLE);

  // The low 64 bits of a product of sign-extended operands equal the signed
  // product, so a single unsigned multiplier shape serves both cases.
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  // Substitute a divisor of 1 so that simulation never divides by zero. The
  // result is discarded in that case anyway.
  assign b_zero    = (B == 32'd0);
  assign divisor_u = b_zero ? 32'd1 : B;

  // Signed division on magnitudes. Using magnitudes makes the rounding
  // explicit: the quotient truncates toward zero and the remainder follows
  // the dividend. It also handles 0x80000000 / -1 without overflow, because
  // the magnitude 2^31 negates back to 0x80000000.
  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = b_zero ? 32'd1 : (B[31] ? (32'd0 - B) : B);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = A[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u   = A / divisor_u;
  assign r_u   = A % divisor_u;

  // -------------------------------------------------------------------------
  // Op decode: classify the op and select the result to be captured.
  // -------------------------------------------------------------------------
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        calc_write;
  logic [63:0] calc_result;

  always_comb begin
    // NOTE: every output of this block gets a default first, so that no path
    // through the case leaves a value unassigned (which would infer a latch).
    is_mul      = 1'b0;
    is_div      = 1'b0;
    is_mthi     = 1'b0;
    is_mtlo     = 1'b0;
    calc_write  = 1'b1;
    calc_result = 64'd0;
    case (mdu_op)
      OP_MULT: begin
        is_mul      = 1'b1;
        calc_result = prod_s;
      end
      OP_MULTU: begin
        is_mul      = 1'b1;
        calc_result = prod_u;
      end
      OP_DIV: begin
        is_div      = 1'b1;
        calc_write  = !b_zero;
        calc_result = {r_s, q_s};
      end
      OP_DIVU: begin
        is_div      = 1'b1;
        calc_write  = !b_zero;
        calc_result = {r_u, q_u};
      end
      OP_MTHI: is_mthi = 1'b1;
      OP_MTLO: is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      // The accumulate base is {hi,lo} as it stands at the accept edge.
      // Nothing else can write hi/lo while the op is in flight.
      OP_MADD: begin
        is_mul      = 1'b1;
        calc_result = {hi, lo} + prod_s;
      end
      OP_MADDU: begin
        is_mul      = 1'b1;
        calc_result = {hi, lo} + prod_u;
      end
      OP_MSUB: begin
        is_mul      = 1'b1;
        calc_result = {hi, lo} - prod_s;
      end
      OP_MSUBU: begin
        is_mul      = 1'b1;
        calc_result = {hi, lo} - prod_u;
      end
`endif
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer and architectural registers. busy is registered: it rises after
  // the accept edge and falls on the commit edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state here uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      busy          <= 1'b0;
      hi            <= 32'd0;
      lo            <= 32'd0;
      pending       <= 64'd0;
      pending_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mthi) hi <= A;
            if (is_mtlo) lo <= A;
            if (is_mul || is_div) begin
              pending       <= calc_result;
              pending_write <= calc_write;
              busy          <= 1'b1;
              state         <= is_mul ? ST_MUL : ST_DIV;
              cnt           <= is_mul ? MUL_LOAD : DIV_LOAD;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // The counter was loaded with N at accept. It reaches zero on the
          // N-th edge after accept, and that edge is the commit edge.
          if (cnt == 4'd1) begin
            if (pending_write) begin
              hi <= pending[63:32];
              lo <= pending[31:0];
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_unit -- directed self-checking bench for mdu_unit (default params).
// Inputs are driven and outputs sampled on the falling clock edge.
// Define MDU_MADD_EN for both the bench and the RTL to cover ops 7..10.
// ---------------------------------------------------------------------------
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        req;
  logic [3:0]  mdu_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec  = 0;
  int n_miss = 0;

  mdu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .req    (req),
    .mdu_op (mdu_op),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for one cycle. Returns on the falling edge after the
  // accept edge k.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    a_in   = a;
    b_in   = b;
    req    = r;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 4'd0;
    req    = 1'b0;
  endtask

  // Count the falling edges on which busy is high. Stops at the first idle
  // sample, which lies just after the commit edge. The count is bounded.
  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    req    = 1'b0;
    mdu_op = 4'd0;
    a_in   = 32'd0;
    b_in   = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check_hilo("reset", 32'd0, 32'd0);
    reset = 1'b0;

    // MULT -2 * 3 = -6
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle("mult_neg", 5);
    check_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU max * max = 0xFFFFFFFE_00000001
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle("multu_max", 5);
    check_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    // DIV -7 / 2 -> q=-3, r=-1
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle("div_neg", 10);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU 7 / 2 -> q=3, r=1
    issue(4'd4, 32'd7, 32'd2, 1'b0);
    wait_idle("divu", 10);
    check_hilo("divu", 32'd1, 32'd3);

    // DIV overflow corner: 0x80000000 / -1
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("div_ovf", 10);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);

    // MTHI: visible the next cycle, busy never rises
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_busy", 64'(busy), 64'd0);
    check_hilo("mthi", 32'h1234_5678, 32'h8000_0000);

    // MTHI cancelled by req
    issue(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("mthi_req_busy", 64'(busy), 64'd0);
    check_hilo("mthi_req", 32'h1234_5678, 32'h8000_0000);

    // MULT cancelled by req: no busy and no change
    issue(4'd1, 32'd9, 32'd9, 1'b1);
    wait_idle("mult_req", 0);
    check_hilo("mult_req", 32'h1234_5678, 32'h8000_0000);

    // Unused op code 11 is ignored
    issue(4'd11, 32'd5, 32'd5, 1'b0);
    wait_idle("op11", 0);
    check_hilo("op11", 32'h1234_5678, 32'h8000_0000);

    // A start during MULT (at edge k+2) is ignored, so only MULT commits
    issue(4'd1, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = 4'd3;
    a_in   = 32'd100;
    b_in   = 32'd3;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 4'd0;
    wait_idle("mult_overlap", 3);
    check_hilo("mult_overlap", 32'd0, 32'd42);
    @(negedge clk);
    check("overlap_no_div", 64'(busy), 64'd0);

    // Asynchronous reset mid-MULT drops busy and clears hi/lo immediately
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check_hilo("async_rst", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_busy", 64'(busy), 64'd0);
    check_hilo("after_rst", 32'd0, 32'd0);

    // Divide by zero: busy for the full latency, hi/lo unchanged
    issue(4'd5, 32'hAAAA_0000, 32'd0, 1'b0);
    issue(4'd6, 32'h0000_5555, 32'd0, 1'b0);
    issue(4'd3, 32'd123, 32'd0, 1'b0);
    wait_idle("div0", 10);
    check_hilo("div0", 32'hAAAA_0000, 32'h0000_5555);

    // MADDU 1*1 on {0, 0xFFFFFFFF}
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    wait_idle("maddu", 5);
    check_hilo("maddu", 32'd1, 32'd0);
    // MSUB 2*3 from 0x1_00000000 -> 0xFFFFFFFA
    issue(4'd9, 32'd2, 32'd3, 1'b0);
    wait_idle("msub", 5);
    check_hilo("msub", 32'd0, 32'hFFFF_FFFA);
`else
    wait_idle("maddu_off", 0);
    check_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
